wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 195 +++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Command-to-Wishbone bridge: takes one command at a time from a valid/ready
// port, runs it as a classic single Wishbone cycle with retry and timeout
// handling, and returns data plus a completion status on a valid/ready port.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 1..65535
  parameter int unsigned MAX_RETRY      = 3     // 0..15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  // Wishbone master
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_GAP,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'b00,
    ST_ERR         = 2'b01,
    ST_TIMEOUT     = 2'b10,
    ST_RETRY_EXH   = 2'b11
  } status_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;

  logic        cmd_ready_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_dat_d;
  logic [1:0]  rsp_status_d;
  logic [31:0] adr_d, dat_d;
  logic [3:0]  sel_d;
  logic        we_d;
  logic        cyc_d;

  // Only classic single cycles are ever issued.
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = rsp_valid_o;
    rsp_dat_d    = rsp_dat_o;
    rsp_status_d = rsp_status_o;
    adr_d        = wb_adr_o;
    dat_d        = wb_dat_o;
    sel_d        = wb_sel_o;
    we_d         = wb_we_o;
    cyc_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          we_d        = cmd_we_i;
          retry_d     = 4'd0;
          tmo_d       = 16'd0;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          state_d     = S_BUS;
        end
      end

      S_BUS: begin
        cyc_d = 1'b1;
        // Priority err > ack > rty, and any response beats the timeout.
        if (wb_err_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = 32'd0;
          rsp_status_d = ST_ERR;
          state_d      = S_RESP;
        end else if (wb_ack_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = wb_we_o ? 32'd0 : wb_dat_i;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            state_d = S_GAP;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_dat_d    = 32'd0;
            rsp_status_d = ST_RETRY_EXH;
            state_d      = S_RESP;
          end
        end else if (tmo_q + 16'd1 == TIMEOUT_LIMIT) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = 32'd0;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      // One idle bus cycle between a retried strobe and its re-issue.
      S_GAP: begin
        tmo_d   = 16'd0;
        cyc_d   = 1'b1;
        state_d = S_BUS;
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs; reset clears everything.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= S_IDLE;
      retry_q      <= 4'd0;
      tmo_q        <= 16'd0;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= 32'd0;
      rsp_status_o <= 2'b00;
      wb_adr_o     <= 32'd0;
      wb_dat_o     <= 32'd0;
      wb_sel_o     <= 4'd0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before the edge, independent of statement order.
      state_q      <= state_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      cmd_ready_o  <= cmd_ready_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_dat_o    <= rsp_dat_d;
      rsp_status_o <= rsp_status_d;
      wb_adr_o     <= adr_d;
      wb_dat_o     <= dat_d;
      wb_sel_o     <= sel_d;
      wb_we_o      <= we_d;
      wb_cyc_o     <= cyc_d;
      wb_stb_o     <= cyc_d;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized
// transactions, each checked against a plan-level model of the slave replies.
module tb_wb_cmd_master;

  localparam int TMO  = 8;
  localparam int MAXR = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // What the slave does during one strobe pulse.
  typedef enum int {K_ACK, K_ERR, K_ERR_ACK, K_ACK_RTY, K_ERR_RTY, K_RTY, K_NONE} kind_e;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_pulses;
  kind_e p_kind [8];
  int    p_delay[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_ack(kind_e k);
    return k == K_ACK || k == K_ERR_ACK || k == K_ACK_RTY;
  endfunction
  function automatic bit has_err(kind_e k);
    return k == K_ERR || k == K_ERR_ACK || k == K_ERR_RTY;
  endfunction
  function automatic bit has_rty(kind_e k);
    return k == K_RTY || k == K_ACK_RTY || k == K_ERR_RTY;
  endfunction

  // Reference model: walk the slave plan and decide how many strobe pulses
  // happen and which status ends the command.
  task automatic model(output int n_used, output logic [1:0] st);
    int retries = 0;
    n_used = n_pulses;
    st = 2'b00;
    for (int p = 0; p < n_pulses; p++) begin
      n_used = p + 1;
      if (has_err(p_kind[p])) begin st = 2'b01; return; end
      if (has_ack(p_kind[p])) begin st = 2'b00; return; end
      if (has_rty(p_kind[p])) begin
        if (retries < MAXR) retries++;
        else begin st = 2'b11; return; end
      end else begin
        st = 2'b10;
        return;
      end
    end
  endtask

  task automatic plan_random();
    int n_rty = $urandom_range(0, MAXR + 1);
    for (int i = 0; i < n_rty; i++) begin
      p_kind[i]  = K_RTY;
      p_delay[i] = $urandom_range(0, TMO - 1);
    end
    if (n_rty <= MAXR) begin
      p_kind[n_rty]  = kind_e'($urandom_range(0, 5) == 5 ? K_NONE : $urandom_range(0, 4));
      p_delay[n_rty] = $urandom_range(0, TMO - 1);
      n_pulses = n_rty + 1;
    end else begin
      n_pulses = n_rty;
    end
  endtask

  // Issue one command at a negedge in IDLE, play the slave plan, check the
  // bus and response ports cycle by cycle, then consume after 'hold' cycles.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rd_data, input int hold);
    int         n_used, len;
    logic [1:0] st;
    logic [31:0] exp_dat;
    model(n_used, st);
    exp_dat = (st == 2'b00 && !we) ? rd_data : 32'd0;

    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);

    for (int p = 0; p < n_used; p++) begin
      len = (p_kind[p] == K_NONE) ? TMO : p_delay[p] + 1;
      for (int i = 0; i < len; i++) begin
        check("stb_high", wb_stb_o, 1);
        check("cyc_high", wb_cyc_o, 1);
        check("adr_hold", wb_adr_o, adr);
        check("dat_hold", wb_dat_o, dat);
        check("sel_hold", wb_sel_o, sel);
        check("we_hold", wb_we_o, we);
        check("cti_bte", {wb_cti_o, wb_bte_o}, 0);
        check("busy_ready", cmd_ready_o, 0);
        check("bus_no_rsp", rsp_valid_o, 0);
        if (p_kind[p] != K_NONE && i == len - 1) begin
          wb_ack_i = has_ack(p_kind[p]);
          wb_err_i = has_err(p_kind[p]);
          wb_rty_i = has_rty(p_kind[p]);
          wb_dat_i = (p == n_used - 1) ? rd_data : $urandom;
        end else begin
          wb_dat_i = $urandom;
        end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        {wb_ack_i, wb_err_i, wb_rty_i} = 3'b000;
      end
      if (p != n_used - 1) begin
        check("gap_stb_low", wb_stb_o, 0);
        check("gap_cyc_low", wb_cyc_o, 0);
        check("gap_no_rsp", rsp_valid_o, 0);
        {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
        wb_dat_i = $urandom;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        {wb_ack_i, wb_err_i, wb_rty_i} = 3'b000;
      end
    end

    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid_o, 1);
      check("rsp_status", rsp_status_o, st);
      check("rsp_dat", rsp_dat_o, exp_dat);
      check("resp_stb_low", wb_stb_o, 0);
      check("resp_ready", cmd_ready_o, 0);
      rsp_ready_i = (h == hold);
      {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
      wb_dat_i = $urandom;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
    rsp_ready_i = 1'b0;
    {wb_ack_i, wb_err_i, wb_rty_i} = 3'b000;
    check("consumed_valid", rsp_valid_o, 0);
    check("consumed_ready", cmd_ready_o, 1);
  endtask

  task automatic reset_mid_bus();
    check("rst_start_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h0000_2000;
    cmd_dat_i = 32'hCAFE_F00D; cmd_sel_i = 4'hF;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    repeat (2) begin
      check("rst_pre_stb", wb_stb_o, 1);
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
    wb_rst_n_i = 1'b0;
    #1;
    check("rst_cyc_drop", wb_cyc_o, 0);
    check("rst_stb_drop", wb_stb_o, 0);
    check("rst_we_clr", wb_we_o, 0);
    check("rst_adr_clr", wb_adr_o, 0);
    check("rst_ready_low", cmd_ready_o, 0);
    check("rst_no_rsp", rsp_valid_o, 0);
    wb_ack_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_held_ready", cmd_ready_o, 0);
    wb_ack_i = 1'b0;
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_rel_ready", cmd_ready_o, 1);
    repeat (3) begin
      check("rst_rel_no_rsp", rsp_valid_o, 0);
      check("rst_rel_stb", wb_stb_o, 0);
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
  endtask

  initial begin
    repeat (2) @(negedge wb_clk_i);
    check("reset_ready", cmd_ready_o, 0);
    check("reset_valid", rsp_valid_o, 0);
    check("reset_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check("reset_adr", wb_adr_o, 0);
    check("reset_dat", wb_dat_o, 0);
    check("reset_sel", wb_sel_o, 0);
    check("reset_rsp", {rsp_dat_o, rsp_status_o}, 0);
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("first_edge_ready", cmd_ready_o, 1);

    // read acked in the second strobe cycle
    n_pulses = 1; p_kind[0] = K_ACK; p_delay[0] = 1;
    run_txn(1'b0, 32'h0000_1040, 32'h0, 4'hF, 32'h1234_5678, 0);
    // write with err and ack together
    n_pulses = 1; p_kind[0] = K_ERR_ACK; p_delay[0] = 0;
    run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'hFFFF_FFFF, 0);
    // retry on every pulse until exhausted
    n_pulses = MAXR + 1;
    for (int i = 0; i < n_pulses; i++) begin p_kind[i] = K_RTY; p_delay[i] = i; end
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h3, 32'h5555_AAAA, 1);
    // silent slave
    n_pulses = 1; p_kind[0] = K_NONE; p_delay[0] = 0;
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h1, 32'h0, 2);
    // ack on the same edge as the timeout limit, response held off 5 cycles
    n_pulses = 1; p_kind[0] = K_ACK; p_delay[0] = TMO - 1;
    run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hC, 32'hA5A5_0F0F, 5);

    reset_mid_bus();

    for (int t = 0; t < 60; t++) begin
      plan_random();
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, $urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) begin
        check("idle_ready", cmd_ready_o, 1);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
